// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
// Consumers: regfile_clear_seq, regfile_mp.
package regfile_pkg;

   // Default geometry of the register file
   localparam int REGFILE_DATA_WIDTH    = 32;
   localparam int REGFILE_NB_OF_REGS    = 32;
   localparam int REGFILE_ADDR_WIDTH    = 5;
   localparam int REGFILE_NB_OF_RD_PORTS = 2;

   // Sequential clear controller states
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_clear_seq.sv
// Sequential clear controller for regfile_mp.
// On a clear request it walks a pointer from 1 up to NB_OF_REGS-1, asking
// the register file to zero one entry per cycle. Register 0 is hardwired
// and therefore skipped. A request arriving while a clear runs is ignored.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int NB_OF_REGS        = REGFILE_NB_OF_REGS,
   parameter int ADDRESS_BIT_WIDTH = REGFILE_ADDR_WIDTH
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         clr_req,
   output logic                         clr_busy,
   output logic                         clr_we,
   output logic [ADDRESS_BIT_WIDTH-1:0] clr_addr
);

   localparam logic [ADDRESS_BIT_WIDTH-1:0] LAST_ADDR  = ADDRESS_BIT_WIDTH'(NB_OF_REGS - 1);
   localparam logic [ADDRESS_BIT_WIDTH-1:0] FIRST_ADDR = ADDRESS_BIT_WIDTH'(1);
   localparam logic [ADDRESS_BIT_WIDTH-1:0] ADDR_STEP  = ADDRESS_BIT_WIDTH'(1);

   clr_state_e                   r_state;
   logic [ADDRESS_BIT_WIDTH-1:0] r_ptr;

   // State and pointer update: start on request, stop after the last entry
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_ptr   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (clr_req) begin
                  r_state <= CLEAR;
                  r_ptr   <= FIRST_ADDR;
               end
            end
            CLEAR: begin
               if (r_ptr == LAST_ADDR) begin
                  r_state <= IDLE;
                  r_ptr   <= '0;
               end else begin
                  r_ptr <= r_ptr + ADDR_STEP;
               end
            end
            default: begin
               r_state <= IDLE;
               r_ptr   <= '0;
            end
         endcase
      end
   end

   assign clr_busy = (r_state == CLEAR);
   assign clr_we   = (r_state == CLEAR);
   assign clr_addr = r_ptr;

endmodule : regfile_clear_seq

// File: rtl/regfile_mp.sv
// Multi-read-port, dual-write-port register file with hardwired register 0
// and a sequential clear engine.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data onto the read ports; otherwise reads return the stored value.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH        = REGFILE_DATA_WIDTH,
   parameter int NB_OF_REGS        = REGFILE_NB_OF_REGS,
   parameter int ADDRESS_BIT_WIDTH = REGFILE_ADDR_WIDTH,
   parameter int NB_OF_RD_PORTS    = REGFILE_NB_OF_RD_PORTS
) (
   input  logic                                        clk,
   input  logic                                        rstn,
   input  logic                                        en,
   input  logic                                        clr_req,
   output logic                                        clr_busy,
   input  logic [NB_OF_RD_PORTS*ADDRESS_BIT_WIDTH-1:0] RA,
   output logic [NB_OF_RD_PORTS*DATA_WIDTH-1:0]        RD,
   input  logic [ADDRESS_BIT_WIDTH-1:0]                WA0,
   input  logic [ADDRESS_BIT_WIDTH-1:0]                WA1,
   input  logic [DATA_WIDTH-1:0]                       WD0,
   input  logic [DATA_WIDTH-1:0]                       WD1,
   input  logic                                        WE0,
   input  logic                                        WE1
);

   localparam int AW = ADDRESS_BIT_WIDTH;
   localparam int DW = DATA_WIDTH;

   logic [DW-1:0] r_mem [NB_OF_REGS];

   logic          w_clr_busy;
   logic          w_clr_we;
   logic [AW-1:0] w_clr_addr;
   logic          w_wr_ok;
   logic          w_we0;
   logic          w_we1;

   regfile_clear_seq #(
      .NB_OF_REGS        (NB_OF_REGS),
      .ADDRESS_BIT_WIDTH (AW)
   ) u_clear_seq (
      .clk      (clk),
      .rstn     (rstn),
      .clr_req  (clr_req),
      .clr_busy (w_clr_busy),
      .clr_we   (w_clr_we),
      .clr_addr (w_clr_addr)
   );

   // Writes are accepted only when enabled, not clearing, and not in the
   // cycle a clear is being requested; address 0 is never written.
   assign w_wr_ok = en & ~w_clr_busy & ~clr_req;
   assign w_we0   = w_wr_ok & WE0 & (WA0 != '0);
   assign w_we1   = w_wr_ok & WE1 & (WA1 != '0);

   // Storage update: clear engine, then port 0, then port 1 (port 1 wins)
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NB_OF_REGS; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
         end
         if (w_we0) begin
            r_mem[WA0] <= WD0;
         end
         if (w_we1) begin
            r_mem[WA1] <= WD1;
         end
      end
   end

   // Combinational read ports with optional write forwarding and gating
   always_comb begin
      logic [AW-1:0] w_ra;
      logic [DW-1:0] w_rd;
      RD   = '0;
      w_ra = '0;
      w_rd = '0;
      for (int k = 0; k < NB_OF_RD_PORTS; k++) begin
         w_ra = RA[k*AW +: AW];
         w_rd = (w_ra == '0) ? '0 : r_mem[w_ra];
`ifdef REGFILE_BYPASS_EN
         if (w_we0 && (WA0 == w_ra)) begin
            w_rd = WD0;
         end
         if (w_we1 && (WA1 == w_ra)) begin
            w_rd = WD1;
         end
`endif
         if (!en || w_clr_busy) begin
            w_rd = '0;
         end
         RD[k*DW +: DW] = w_rd;
      end
   end

   assign clr_busy = w_clr_busy;

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: directed vector table, hand-written clear and
// reset-during-clear sequences, and randomized traffic against a model.
module tb_regfile_mp;

   localparam int DW  = 32;
   localparam int NB  = 32;
   localparam int AW  = 5;
   localparam int NRP = 2;

`ifdef REGFILE_BYPASS_EN
   localparam logic [DW-1:0] BYP9 = 32'h0000_00A5;
`else
   localparam logic [DW-1:0] BYP9 = 32'h0000_0077;
`endif

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              en = 1'b0;
   logic              clr_req = 1'b0;
   logic              clr_busy;
   logic [NRP*AW-1:0] RA = '0;
   logic [NRP*DW-1:0] RD;
   logic [AW-1:0]     WA0 = '0;
   logic [AW-1:0]     WA1 = '0;
   logic [DW-1:0]     WD0 = '0;
   logic [DW-1:0]     WD1 = '0;
   logic              WE0 = 1'b0;
   logic              WE1 = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: register contents and remaining clear cycles
   logic [DW-1:0] m [NB];
   int            busy_left = 0;

   typedef struct {
      logic          en;
      logic          we0;
      logic [AW-1:0] wa0;
      logic [DW-1:0] wd0;
      logic          we1;
      logic [AW-1:0] wa1;
      logic [DW-1:0] wd1;
      logic [AW-1:0] ra0;
      logic [AW-1:0] ra1;
      logic [DW-1:0] e0;
      logic [DW-1:0] e1;
   } vec_t;

   vec_t tbl [10];

   regfile_mp #(
      .DATA_WIDTH        (DW),
      .NB_OF_REGS        (NB),
      .ADDRESS_BIT_WIDTH (AW),
      .NB_OF_RD_PORTS    (NRP)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .en       (en),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .RA       (RA),
      .RD       (RD),
      .WA0      (WA0),
      .WA1      (WA1),
      .WD0      (WD0),
      .WD1      (WD1),
      .WE0      (WE0),
      .WE1      (WE1)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input int e, input int we0, input int wa0, input int wd0,
                               input int we1, input int wa1, input int wd1,
                               input int ra0, input int ra1, input logic [DW-1:0] e0,
                               input logic [DW-1:0] e1);
      vec_t v;
      v.en  = e[0];
      v.we0 = we0[0];
      v.wa0 = AW'(wa0);
      v.wd0 = DW'(wd0);
      v.we1 = we1[0];
      v.wa1 = AW'(wa1);
      v.wd1 = DW'(wd1);
      v.ra0 = AW'(ra0);
      v.ra1 = AW'(ra1);
      v.e0  = e0;
      v.e1  = e1;
      return v;
   endfunction

   // Expected read value for address a under the current inputs
   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
      logic [DW-1:0] v;
      if (!rstn || !en || busy_left > 0) return '0;
      v = (a == 0) ? '0 : m[a];
`ifdef REGFILE_BYPASS_EN
      if (!clr_req && a != 0) begin
         if (WE0 && WA0 == a) v = WD0;
         if (WE1 && WA1 == a) v = WD1;
      end
`endif
      return v;
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic check_model(input string tag);
      for (int k = 0; k < NRP; k++) begin
         check($sformatf("%s rd%0d", tag, k), RD[k*DW +: DW], exp_rd(RA[k*AW +: AW]));
      end
      check({tag, " busy"}, 32'(clr_busy), (busy_left > 0) ? 32'd1 : 32'd0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NB; i++) m[i] = '0;
      busy_left = 0;
   endtask

   // Advance one clock; the model applies the rules sampled at that edge
   task automatic step();
      @(posedge clk);
      if (rstn) begin
         if (busy_left > 0) begin
            busy_left--;
         end else if (clr_req) begin
            busy_left = NB - 1;
            for (int i = 0; i < NB; i++) m[i] = '0;
         end else if (en) begin
            if (WE0 && WA0 != 0) m[WA0] = WD0;
            if (WE1 && WA1 != 0) m[WA1] = WD1;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      WE0 = 1'b0; WE1 = 1'b0; clr_req = 1'b0;
   endtask

   // Read back every register through both ports, one cycle per address
   task automatic sweep(input string tag);
      idle_inputs();
      for (int r = 0; r < NB; r++) begin
         RA = {AW'(NB - 1 - r), AW'(r)};
         #1;
         check_model($sformatf("%s r%0d", tag, r));
         step();
      end
   endtask

   initial begin
      int nb;
      model_reset();

      // Reset state
      en = 1'b1;
      RA = {AW'(5), AW'(7)};
      #12;
      check_model("reset");
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // Directed vector table
      tbl[0] = mk(1, 1, 5, 'h2004, 0, 0, 0,     1, 2, 32'h0,    32'h0);
      tbl[1] = mk(1, 0, 0, 0,      0, 0, 0,     5, 0, 32'h2004, 32'h0);
      tbl[2] = mk(1, 1, 7, 'h11,   1, 7, 'h22,  5, 1, 32'h2004, 32'h0);
      tbl[3] = mk(1, 1, 0, 'hFFFF, 0, 0, 0,     7, 3, 32'h22,   32'h0);
      tbl[4] = mk(1, 0, 0, 0,      0, 0, 0,     0, 7, 32'h0,    32'h22);
      tbl[5] = mk(0, 1, 3, 'h55,   0, 0, 0,     7, 5, 32'h0,    32'h0);
      tbl[6] = mk(1, 0, 0, 0,      0, 0, 0,     3, 7, 32'h0,    32'h22);
      tbl[7] = mk(1, 1, 9, 'h77,   0, 0, 0,     5, 7, 32'h2004, 32'h22);
      tbl[8] = mk(1, 0, 0, 0,      1, 9, 'hA5,  5, 9, 32'h2004, BYP9);
      tbl[9] = mk(1, 0, 0, 0,      0, 0, 0,     9, 9, 32'hA5,   32'hA5);
      for (int i = 0; i < 10; i++) begin
         en  = tbl[i].en;
         WE0 = tbl[i].we0; WA0 = tbl[i].wa0; WD0 = tbl[i].wd0;
         WE1 = tbl[i].we1; WA1 = tbl[i].wa1; WD1 = tbl[i].wd1;
         RA  = {tbl[i].ra1, tbl[i].ra0};
         #1;
         check($sformatf("vec%0d rd0", i), RD[DW-1:0], tbl[i].e0);
         check($sformatf("vec%0d rd1", i), RD[2*DW-1:DW], tbl[i].e1);
         step();
      end
      idle_inputs();
      en = 1'b1;

      // Fill registers 1..31, then run a full clear
      for (int r = 1; r < NB; r++) begin
         WE0 = 1'b1; WA0 = AW'(r); WD0 = $urandom;
         RA = {AW'(r - 1), AW'($urandom_range(0, NB - 1))};
         #1;
         check_model($sformatf("fill%0d", r));
         step();
      end
      sweep("filled");
      clr_req = 1'b1; WE0 = 1'b1; WA0 = AW'(4); WD0 = 32'hDEAD_BEEF;
      RA = {AW'(4), AW'(6)};
      #1;
      check_model("clr_req");
      step();
      nb = 0;
      for (int c = 0; c < 40; c++) begin
         WE0 = 1'b1; WA0 = AW'($urandom_range(1, NB - 1)); WD0 = $urandom;
         WE1 = 1'b1; WA1 = AW'($urandom_range(1, NB - 1)); WD1 = $urandom;
         clr_req = (c == 5);
         RA = {AW'($urandom_range(0, NB - 1)), AW'($urandom_range(0, NB - 1))};
         #1;
         if (!clr_busy) break;
         nb++;
         check_model($sformatf("busy%0d", c));
         step();
      end
      idle_inputs();
      check("busy length", 32'(nb), 32'(NB - 1));
      busy_left = 0;
      sweep("cleared");

      // Reset in the middle of a clear
      for (int r = 1; r < 6; r++) begin
         WE0 = 1'b1; WA0 = AW'(r * 5); WD0 = $urandom | 32'h1;
         #1;
         step();
      end
      clr_req = 1'b1; WE0 = 1'b0;
      #1;
      step();
      clr_req = 1'b0;
      for (int c = 1; c < 10; c++) begin
         #1;
         check_model($sformatf("preabort%0d", c));
         step();
      end
      #2;
      rstn = 1'b0;
      model_reset();
      #1;
      check_model("abort");
      @(negedge clk);
      rstn = 1'b1;
      step();
      sweep("postabort");

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         en      = ($urandom_range(0, 9) != 0);
         clr_req = ($urandom_range(0, 49) == 0);
         WE0 = $urandom_range(0, 1); WA0 = AW'($urandom_range(0, NB - 1)); WD0 = $urandom;
         WE1 = $urandom_range(0, 1);
         WA1 = ($urandom_range(0, 3) == 0) ? WA0 : AW'($urandom_range(0, NB - 1));
         WD1 = $urandom;
         RA[AW-1:0]    = ($urandom_range(0, 2) == 0) ? WA0 : AW'($urandom_range(0, NB - 1));
         RA[2*AW-1:AW] = ($urandom_range(0, 2) == 0) ? WA1 : AW'($urandom_range(0, NB - 1));
         #1;
         check_model($sformatf("rand%0d", c));
         step();
      end
      idle_inputs();
      en = 1'b1;
      for (int c = 0; c < NB; c++) begin
         if (busy_left == 0) break;
         step();
      end
      sweep("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 SHALL have parameter NB_OF_REGS, default 32, register count; legal values are powers of two, minimum 4.
REQ-003 SHALL have parameter ADDRESS_BIT_WIDTH, default 5, equal to log2(NB_OF_REGS).
REQ-004 SHALL have parameter NB_OF_RD_PORTS, default 2, number of read ports, range 1..4.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port en, input, 1, block enable.
REQ-008 SHALL have port clr_req, input, 1, single-cycle request to start a sequential clear.
REQ-009 SHALL have port clr_busy, output, 1, high while the clear sequence runs.
REQ-010 SHALL have port RA, input, NB_OF_RD_PORTS*ADDRESS_BIT_WIDTH, packed read addresses; port k occupies slice k.
REQ-011 SHALL have port RD, output, NB_OF_RD_PORTS*DATA_WIDTH, packed read data; port k occupies slice k.
REQ-012 SHALL have ports WA0 and WA1, input, ADDRESS_BIT_WIDTH each, write addresses.
REQ-013 SHALL have ports WD0 and WD1, input, DATA_WIDTH each, write data.
REQ-014 SHALL have ports WE0 and WE1, input, 1 each, write enables.

Function
REQ-015 SHALL make reads combinational: RD[k] = mem[RA[k]] in the same cycle.
REQ-016 SHALL hardwire register 0: it always reads 0, and writes to address 0 SHALL be dropped.
REQ-017 SHALL write WDn to mem[WAn] at the rising edge when WEn=1, en=1, clr_busy=0 and clr_req=0.
REQ-018 SHALL let port 1 win when WA0==WA1 and both write enables are high; port 0's write is dropped.
REQ-019 SHALL drive all RD slices to 0 when en=0 or clr_busy=1; writes are ignored while en=0.
REQ-020 SHALL implement a clear FSM with states IDLE and CLEAR.
REQ-021 SHALL move IDLE->CLEAR on clr_req=1 and load the pointer with 1; en does not gate this transition.
REQ-022 SHALL, in CLEAR, write 0 to mem[ptr] each cycle and increment ptr; after writing NB_OF_REGS-1 it returns to IDLE.
REQ-023 SHALL make clr_busy=1 exactly in CLEAR, for NB_OF_REGS-1 cycles; the first busy cycle is the one after clr_req is sampled.
REQ-024 SHALL ignore clr_req while in CLEAR.
REQ-025 SHALL drop writes presented in the same cycle clr_req is sampled in IDLE.

Reset
REQ-026 SHALL, on rstn=0, asynchronously zero all registers, force the FSM to IDLE, clear ptr and make clr_busy=0; RD reads 0.
REQ-027 SHALL abort a clear in progress when rstn is asserted; after release the block is in IDLE with all registers zero.

Configuration
REQ-028 SHALL, with macro REGFILE_BYPASS_EN defined, forward same-cycle write data: RD[k] returns WDn when WEn=1, WAn==RA[k]!=0 and a write is legal per REQ-017; port 1 has priority over port 0.
REQ-029 SHALL, without REGFILE_BYPASS_EN, return the pre-write stored value in the write cycle.
REQ-030 SHALL let REQ-019 override bypass in both builds.

Structure
REQ-031 SHALL place the FSM state enum (IDLE, CLEAR) and the default width/depth constants in shared package regfile_pkg.
REQ-032 SHALL implement the clear FSM and pointer as sub-module regfile_clear_seq, outputs clr_busy, clr_we and clr_addr.

Verification
REQ-033 SHALL cover reset and basic write/read: release rstn, en=1; WE0=1, WA0=5, WD0=0x2004; next cycle RA[0]=5 -> RD[0]=0x2004.
REQ-034 SHALL cover the write conflict: WA0=WA1=7, WD0=0x11, WD1=0x22, both enables high -> reg 7 reads 0x22; WA0=0, WD0=0xFFFF -> reg 0 reads 0.
REQ-035 SHALL cover bypass: RA[1]=9, WA1=9, WD1=0xA5 in the same cycle -> RD[1]=0xA5 with REGFILE_BYPASS_EN defined, old value without it.
REQ-036 SHALL cover clear: fill regs 1..31, pulse clr_req -> clr_busy high for exactly 31 cycles, RD=0 throughout, all regs 0 afterwards; writes and a second clr_req issued during busy have no effect.
REQ-037 SHALL cover reset mid-clear: assert rstn at busy cycle 10 -> clr_busy=0 immediately; after release all regs read 0 and the FSM is in IDLE.
REQ-038 SHALL cover enable gating: en=0 with WE0=1, WA0=3, WD0=0x55 -> RD=0 and reg 3 is unchanged once en returns to 1.
